alu_step_sequencer: RTL and testbench

- Board-level controller that sequences the shared 16-bit ALU from one 10-bit switch bank and two active-low pushbuttons.
- Guides the user through a fixed order: load Rsrc, load Rdest, load OpCode. It then waits a fixed ALU settle time, captures the result and flags, and holds them for the display.
- Replaces the asynchronous per-button loading with a single-clock, debounced, FSM-driven sequence.
- The ALU and the 7-segment decoders are instantiated beside this block, not inside it.

---
 rtl/alu_seq_pkg.sv | 19 +
 rtl/alu_step_sequencer_btn_debounce.sv | 40 ++++
 rtl/alu_step_sequencer.sv | 98 +++++++++
 tb/tb_alu_step_sequencer.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared types and widths for the ALU step sequencer slice.
// State encodings are visible on the LEDs, so their values are fixed.
package alu_seq_pkg;

   localparam int SWITCH_W    = 10;
   localparam int OPERAND_W   = 16;
   localparam int OPCODE_W    = 5;
   localparam int FLAG_W      = 5;
   localparam int OPERAND_PAD = 6;

   typedef enum logic [2:0] {
      S_SRC  = 3'd0,
      S_DEST = 3'd1,
      S_OP   = 3'd2,
      S_EXEC = 3'd3,
      S_SHOW = 3'd4
   } state_t;

endpackage

// File: rtl/alu_step_sequencer_btn_debounce.sv
// Debounced press detector for one active-low pushbutton.
// Emits a single-cycle pulse when the accepted level falls; releases are silent.
module btn_debounce #(
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_n,
   output logic press
);

   localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

   logic [1:0]    sync_q;
   logic          stable;
   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '1;
         stable <= 1'b1;
         cnt    <= '0;
         press  <= 1'b0;
      end else begin
         sync_q <= {sync_q[0], btn_n};
         press  <= 1'b0;
         if (sync_q[1] == stable) begin
            cnt <= '0;
         end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
            // Level accepted; only a new low level counts as a press.
            stable <= sync_q[1];
            cnt    <= '0;
            press  <= ~sync_q[1];
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/alu_step_sequencer.sv
// Step-by-step loader for the shared ALU: Rsrc, Rdest, OpCode, then a
// timed capture of result and flags held for the display.
import alu_seq_pkg::*;

module alu_step_sequencer #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int ALU_LAT         = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [SWITCH_W-1:0]  data_in,
   input  logic [1:0]           btn_n,
   input  logic [OPERAND_W-1:0] alu_out,
   input  logic [FLAG_W-1:0]    alu_flags,
   output logic [OPERAND_W-1:0] alu_rsrc,
   output logic [OPERAND_W-1:0] alu_rdest,
   output logic [OPCODE_W-1:0]  alu_opcode,
   output logic [OPERAND_W-1:0] result,
   output logic [FLAG_W-1:0]    flags_q,
   output logic [2:0]           state_o,
   output logic                 busy,
   output logic                 done
);

   localparam int LW = (ALU_LAT > 0) ? $clog2(ALU_LAT + 1) : 1;

   state_t               state, state_nx;
   logic [LW-1:0]        lat_cnt;
   logic                 step_ev, abort_ev;
   logic                 ld_src, ld_dest, ld_op, capture;
   logic [OPERAND_W-1:0] operand;

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step (
      .clk(clk), .rst_n(rst_n), .btn_n(btn_n[0]), .press(step_ev)
   );

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_abort (
      .clk(clk), .rst_n(rst_n), .btn_n(btn_n[1]), .press(abort_ev)
   );

   assign operand = {data_in, {OPERAND_PAD{1'b0}}};
   assign state_o = state;

   always_comb begin
      state_nx = state;
      ld_src   = 1'b0;
      ld_dest  = 1'b0;
      ld_op    = 1'b0;
      capture  = 1'b0;
      // Abort pre-empts everything, including a pending capture.
      if (abort_ev) begin
         state_nx = S_SRC;
      end else begin
         case (state)
            S_SRC:  if (step_ev) begin ld_src  = 1'b1; state_nx = S_DEST; end
            S_DEST: if (step_ev) begin ld_dest = 1'b1; state_nx = S_OP;   end
            S_OP:   if (step_ev) begin ld_op   = 1'b1; state_nx = S_EXEC; end
            S_EXEC: if (lat_cnt == LW'(ALU_LAT)) begin
                       capture  = 1'b1;
                       state_nx = S_SHOW;
                    end
            S_SHOW: if (step_ev) state_nx = S_SRC;
            default: state_nx = S_SRC;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_SRC;
         lat_cnt    <= '0;
         alu_rsrc   <= '0;
         alu_rdest  <= '0;
         alu_opcode <= '0;
         result     <= '0;
         flags_q    <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         state <= state_nx;
         if (ld_src)  alu_rsrc  <= operand;
         if (ld_dest) alu_rdest <= operand;
         if (ld_op) begin
            alu_opcode <= data_in[OPCODE_W-1:0];
            lat_cnt    <= '0;
         end else if (state == S_EXEC) begin
            lat_cnt <= lat_cnt + 1'b1;
         end
         if (capture) begin
            result  <= alu_out;
            flags_q <= alu_flags;
         end
         done <= capture;
         busy <= (state_nx == S_EXEC);
      end
   end

endmodule

// File: tb/tb_alu_step_sequencer.sv
// Scoreboard bench: two sequencers (ALU_LAT=1 and ALU_LAT=0) share stimulus,
// each beside a behavioural ALU; only one is out of reset at a time.
module tb_alu_step_sequencer;

   typedef struct {
      int          tag;
      logic [15:0] res;
      logic [4:0]  fl;
   } exp_t;

   logic        clk;
   logic        rst_a, rst_b;
   logic [9:0]  data_in;
   logic [1:0]  btn_n;

   logic [15:0] rsrc_a, rdest_a, res_a, aout_a, rsrc_b, rdest_b, res_b, aout_b;
   logic [4:0]  op_a, fl_a, afl_a, op_b, fl_b, afl_b;
   logic [2:0]  st_a, st_b;
   logic        busy_a, done_a, busy_b, done_b;

   int   n_checks = 0;
   int   n_fail   = 0;
   exp_t sb_q[$];
   int   prev_st[2];
   int   exec_len[2];
   logic [15:0] m_rsrc, m_rdest;

   function automatic logic [15:0] alu_f(input logic [15:0] rs, input logic [15:0] rd,
                                         input logic [4:0] op);
      case (op)
         5'h00:   return rd + rs;
         5'h01:   return rd - rs;
         5'h02:   return rd & rs;
         5'h03:   return rd | rs;
         5'h04:   return rd ^ rs;
         5'h1F:   return 16'h1234;   // fixed display test pattern
         default: return rd;
      endcase
   endfunction

   function automatic logic [4:0] flag_f(input logic [15:0] rs, input logic [15:0] rd,
                                         input logic [4:0] op);
      logic [15:0] r;
      r = alu_f(rs, rd, op);
      return {r == 16'h0, r[15], ^r, op[1:0]};
   endfunction

   assign aout_a = alu_f(rsrc_a, rdest_a, op_a);
   assign afl_a  = flag_f(rsrc_a, rdest_a, op_a);
   assign aout_b = alu_f(rsrc_b, rdest_b, op_b);
   assign afl_b  = flag_f(rsrc_b, rdest_b, op_b);

   alu_step_sequencer #(.DEBOUNCE_CYCLES(4), .ALU_LAT(1)) dut (
      .clk(clk), .rst_n(rst_a), .data_in(data_in), .btn_n(btn_n),
      .alu_out(aout_a), .alu_flags(afl_a), .alu_rsrc(rsrc_a), .alu_rdest(rdest_a),
      .alu_opcode(op_a), .result(res_a), .flags_q(fl_a), .state_o(st_a),
      .busy(busy_a), .done(done_a)
   );

   alu_step_sequencer #(.DEBOUNCE_CYCLES(4), .ALU_LAT(0)) dut0 (
      .clk(clk), .rst_n(rst_b), .data_in(data_in), .btn_n(btn_n),
      .alu_out(aout_b), .alu_flags(afl_b), .alu_rsrc(rsrc_b), .alu_rdest(rdest_b),
      .alu_opcode(op_b), .result(res_b), .flags_q(fl_b), .state_o(st_b),
      .busy(busy_b), .done(done_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: busy must track S_EXEC; every done must be announced in the
   // scoreboard and follow an S_EXEC run of exactly ALU_LAT+1 cycles.
   task automatic mon(input int i, input logic rst, input logic [2:0] st, input logic bsy,
                      input logic dn, input logic [15:0] res, input logic [4:0] fl);
      exp_t e;
      if (!rst) begin
         prev_st[i]  = 0;
         exec_len[i] = 0;
         return;
      end
      check($sformatf("busy_tracks_exec[%0d]", i), bsy, st == 3'd3);
      if (dn) begin
         check($sformatf("done_expected[%0d]", i), (sb_q.size() > 0) && (sb_q[0].tag == i), 1);
         check($sformatf("done_latency[%0d]", i), (prev_st[i] == 3) ? exec_len[i] : 0,
               (i == 0) ? 2 : 1);
         check($sformatf("done_state[%0d]", i), st, 3'd4);
         if (sb_q.size() > 0 && sb_q[0].tag == i) begin
            e = sb_q.pop_front();
            check($sformatf("result[%0d]", i), res, e.res);
            check($sformatf("flags_q[%0d]", i), fl, e.fl);
         end
      end
      if (st == 3'd3) exec_len[i] = (prev_st[i] == 3) ? exec_len[i] + 1 : 1;
      prev_st[i] = st;
   endtask

   always @(negedge clk) begin
      mon(0, rst_a, st_a, busy_a, done_a, res_a, fl_a);
      mon(1, rst_b, st_b, busy_b, done_b, res_b, fl_b);
   end

   task automatic press(input logic [1:0] mask);
      btn_n = ~mask;
      repeat (12) @(negedge clk);
      btn_n = 2'b11;
      repeat (12) @(negedge clk);
   endtask

   task automatic step(input logic [9:0] d);
      data_in = d;
      press(2'b01);
   endtask

   task automatic push(input int tag, input logic [4:0] op);
      exp_t e;
      e.tag = tag;
      e.res = alu_f(m_rsrc, m_rdest, op);
      e.fl  = flag_f(m_rsrc, m_rdest, op);
      sb_q.push_back(e);
   endtask

   initial begin
      int          trans;
      logic [2:0]  last;
      logic [9:0]  d1, d2;
      logic [4:0]  op;
      bit          seen;

      rst_a = 1'b0; rst_b = 1'b0; btn_n = 2'b11; data_in = '0;
      repeat (3) @(negedge clk);
      check("rst_rsrc", rsrc_a, 0);
      check("rst_rdest", rdest_a, 0);
      check("rst_opcode", op_a, 0);
      check("rst_result", res_a, 0);
      check("rst_flags", fl_a, 0);
      check("rst_state", st_a, 0);
      check("rst_busy", busy_a, 0);
      check("rst_done", done_a, 0);
      rst_a = 1'b1;
      repeat (3) @(negedge clk);

      // Short glitches never survive the debounce window.
      data_in = 10'h3FF;
      for (int g = 0; g < 4; g++) begin
         btn_n = 2'b10; repeat (2) @(negedge clk);
         btn_n = 2'b11; repeat (6) @(negedge clk);
      end
      check("glitch_state", st_a, 0);
      check("glitch_rsrc", rsrc_a, 0);

      // A long hold and its release give exactly one step.
      data_in = 10'h001; trans = 0; last = st_a; btn_n = 2'b10;
      for (int c = 0; c < 70; c++) begin
         if (c == 50) btn_n = 2'b11;
         @(negedge clk);
         if (st_a != last) trans++;
         last = st_a;
      end
      check("hold_transitions", trans, 1);
      check("hold_state", st_a, 1);
      m_rsrc = 16'h0040;
      check("full_rsrc", rsrc_a, m_rsrc);

      step(10'h002);
      m_rdest = 16'h0080;
      check("full_state_op", st_a, 2);
      check("full_rdest", rdest_a, m_rdest);
      push(0, 5'h00);
      step(10'h000);
      check("full_state_show", st_a, 4);
      check("full_result", res_a, 16'h00C0);
      step(10'h000);
      check("show_to_src", st_a, 0);

      // Abort lands in the first S_EXEC cycle and cancels the capture.
      step(10'h003); m_rsrc  = 16'h00C0;
      step(10'h005); m_rdest = 16'h0140;
      data_in = 10'h001;
      btn_n = 2'b10; @(negedge clk);
      btn_n = 2'b00;
      seen = 1'b0;
      for (int c = 0; c < 20 && !seen; c++) begin
         @(negedge clk);
         if (st_a == 3'd3) seen = 1'b1;
      end
      check("abort_reached_exec", seen, 1);
      @(negedge clk);
      check("abort_next_state", st_a, 0);
      btn_n = 2'b11;
      repeat (14) @(negedge clk);
      check("abort_result_held", res_a, 16'h00C0);
      check("abort_rsrc_held", rsrc_a, m_rsrc);
      check("abort_rdest_held", rdest_a, m_rdest);

      // Step and abort together in S_DEST: abort wins.
      step(10'h007); m_rsrc = 16'h01C0;
      check("simul_pre_state", st_a, 1);
      data_in = 10'h3AA;
      press(2'b11);
      check("simul_state", st_a, 0);
      check("simul_rdest_held", rdest_a, m_rdest);

      for (int k = 0; k < 5; k++) begin
         d1 = 10'($urandom_range(0, 1023));
         d2 = 10'($urandom_range(0, 1023));
         op = 5'($urandom_range(0, 4));
         step(d1); m_rsrc  = {d1, 6'b0};
         check("rand_rsrc", rsrc_a, m_rsrc);
         step(d2); m_rdest = {d2, 6'b0};
         check("rand_rdest", rdest_a, m_rdest);
         push(0, op);
         step({5'b0, op});
         check("rand_opcode", op_a, op);
         check("rand_state_show", st_a, 4);
         step(10'h000);
      end

      // Reset between clock edges while showing 16'h1234.
      step(10'h011); m_rsrc  = 16'h0440;
      step(10'h022); m_rdest = 16'h0880;
      push(0, 5'h1F);
      step(10'h01F);
      check("pattern_result", res_a, 16'h1234);
      #2 rst_a = 1'b0;
      #1;
      check("async_result", res_a, 0);
      check("async_flags", fl_a, 0);
      check("async_state", st_a, 0);
      check("async_busy", busy_a, 0);

      // ALU_LAT=0 instance runs the basic sequence.
      @(negedge clk);
      rst_b = 1'b1;
      repeat (3) @(negedge clk);
      step(10'h001); m_rsrc  = 16'h0040;
      step(10'h002); m_rdest = 16'h0080;
      push(1, 5'h00);
      step(10'h000);
      check("lat0_state", st_b, 4);
      check("lat0_result", res_b, 16'h00C0);

      repeat (10) @(negedge clk);
      check("scoreboard_drained", sb_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
